radar_sweep_ctrl: RTL and testbench

Sequencer for the radar servo and the ultrasonic range channel. It drives the 3-bit servo position code (`ctr`) in a ping-pong sweep across positions 1..7. At each position it waits a servo settle time, then issues one range measurement over a start/done handshake. It publishes a (position, distance, timeout) sample with a one-cycle valid strobe. It sits between the top-level enable and the servo PWM and ranging blocks.

---
 rtl/radar_pkg.sv | 43 ++++
 rtl/radar_cycle_timer.sv | 27 ++
 rtl/radar_sweep_ctrl.sv | 121 ++++++++++++
 tb/tb_radar_sweep_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/radar_pkg.sv
// Shared types and constants for the radar sweep sequencer.
package radar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_TRIG,
    ST_WAIT,
    ST_REPORT,
    ST_STEP
  } radar_state_t;

  localparam logic [2:0]  RADAR_POS_MIN       = 3'd1;
  localparam logic [2:0]  RADAR_POS_MAX       = 3'd7;
  // Wide enough for any practical distance width; sliced to DIST_W by users.
  localparam logic [63:0] RADAR_TIMEOUT_DIST  = '1;
  localparam int          RADAR_SETTLE_CYCLES = 15_000_000;
  localparam int          RADAR_MEAS_TIMEOUT  = 3_000_000;

  // Ping-pong step: returns {next_up, next_pos}. Endpoints reverse direction
  // and bounce straight off, so each endpoint is visited once per turn.
  function automatic logic [3:0] radar_next_pos(input logic       up,
                                                input logic [2:0] pos,
                                                input logic [2:0] pmin,
                                                input logic [2:0] pmax);
    logic       nup;
    logic [2:0] npos;
    nup = up;
    if (up && pos == pmax) begin
      nup  = 1'b0;
      npos = pmax - 3'd1;
    end else if (!up && pos == pmin) begin
      nup  = 1'b1;
      npos = pmin + 3'd1;
    end else if (up) begin
      npos = pos + 3'd1;
    end else begin
      npos = pos - 3'd1;
    end
    return {nup, npos};
  endfunction

endpackage

// File: rtl/radar_cycle_timer.sv
// Clearable up-counter with terminal-count compare, shared by settle and wait.
module radar_cycle_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Count while not cleared; the controller leaves the counting state at tc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/radar_sweep_ctrl.sv
// Servo sweep / range measurement sequencer: settle, trigger, wait, report, step.
module radar_sweep_ctrl
  import radar_pkg::*;
#(
  parameter int         SETTLE_CYCLES = RADAR_SETTLE_CYCLES,
  parameter int         MEAS_TIMEOUT  = RADAR_MEAS_TIMEOUT,
  parameter logic [2:0] POS_MIN       = RADAR_POS_MIN,
  parameter logic [2:0] POS_MAX       = RADAR_POS_MAX,
  parameter int         DIST_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              meas_done,
  input  logic [DIST_W-1:0] meas_dist,
  output logic [2:0]        ctr,
  output logic              meas_start,
  output logic              sample_valid,
  output logic [2:0]        sample_pos,
  output logic [DIST_W-1:0] sample_dist,
  output logic              sample_timeout,
  output logic              sweep_up,
  output logic              busy
);

  localparam int MAX_CYC = (SETTLE_CYCLES > MEAS_TIMEOUT) ? SETTLE_CYCLES : MEAS_TIMEOUT;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_TC    = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WAIT_TC      = CNT_W'(MEAS_TIMEOUT - 1);
  localparam logic [DIST_W-1:0] TIMEOUT_DIST = RADAR_TIMEOUT_DIST[DIST_W-1:0];

  radar_state_t     state;
  logic             tmr_clr;
  logic             tmr_tc;
  logic [CNT_W-1:0] tmr_tc_val;
  logic [3:0]       step_nxt;

  // Timer runs only in SETTLE and WAIT; every other state holds it at zero,
  // so it is already cleared on entry to either counting state.
  assign tmr_clr    = !(state == ST_SETTLE || state == ST_WAIT);
  assign tmr_tc_val = (state == ST_WAIT) ? WAIT_TC : SETTLE_TC;
  assign step_nxt   = radar_next_pos(sweep_up, ctr, POS_MIN, POS_MAX);

  radar_cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .tc_val (tmr_tc_val),
    .tc     (tmr_tc)
  );

  // Sequencer FSM with registered strobes, sample capture and position stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      ctr            <= POS_MIN;
      sweep_up       <= 1'b1;
      meas_start     <= 1'b0;
      sample_valid   <= 1'b0;
      sample_pos     <= 3'd0;
      sample_dist    <= '0;
      sample_timeout <= 1'b0;
      busy           <= 1'b0;
    end else begin
      meas_start   <= 1'b0;
      sample_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_SETTLE;
            busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (tmr_tc) begin
            state      <= ST_TRIG;
            meas_start <= 1'b1;
          end
        end
        ST_TRIG: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A reply on the terminal cycle still counts as a valid measurement.
          if (meas_done) begin
            state          <= ST_REPORT;
            sample_valid   <= 1'b1;
            sample_pos     <= ctr;
            sample_dist    <= meas_dist;
            sample_timeout <= 1'b0;
          end else if (tmr_tc) begin
            state          <= ST_REPORT;
            sample_valid   <= 1'b1;
            sample_pos     <= ctr;
            sample_dist    <= TIMEOUT_DIST;
            sample_timeout <= 1'b1;
          end
        end
        ST_REPORT: begin
          state <= ST_STEP;
        end
        ST_STEP: begin
          {sweep_up, ctr} <= step_nxt;
          if (enable) begin
            state <= ST_SETTLE;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_radar_sweep_ctrl.sv
// Self-checking bench for radar_sweep_ctrl with a timeline-based reference model.
module tb_radar_sweep_ctrl;

  localparam int S  = 4;
  localparam int T  = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          meas_done = 1'b0;
  logic [DW-1:0] meas_dist = '0;
  logic [2:0]    ctr;
  logic          meas_start;
  logic          sample_valid;
  logic [2:0]    sample_pos;
  logic [DW-1:0] sample_dist;
  logic          sample_timeout;
  logic          sweep_up;
  logic          busy;

  radar_sweep_ctrl #(
    .SETTLE_CYCLES (S),
    .MEAS_TIMEOUT  (T),
    .POS_MIN       (3'd1),
    .POS_MAX       (3'd7),
    .DIST_W        (DW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .meas_done      (meas_done),
    .meas_dist      (meas_dist),
    .ctr            (ctr),
    .meas_start     (meas_start),
    .sample_valid   (sample_valid),
    .sample_pos     (sample_pos),
    .sample_dist    (sample_dist),
    .sample_timeout (sample_timeout),
    .sweep_up       (sweep_up),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Ranging stand-in configuration (0 delay = never answers)
  int            rsp_delay = 3;
  logic [DW-1:0] rsp_dist  = 16'h0123;
  int            rsp_cnt   = 0;
  int            stray_cyc = -1;

  // Reference model state: absolute cycle numbers of the next trigger/report
  bit            m_busy  = 1'b0;
  int            trig    = -100;
  int            rep     = -100;
  int            idx     = 0;
  logic          e_start = 1'b0;
  logic          e_valid = 1'b0;
  logic          e_busy  = 1'b0;
  logic [2:0]    e_spos  = 3'd0;
  logic [DW-1:0] e_sdist = '0;
  logic          e_sto   = 1'b0;

  // Observed sample log
  int n_samples = 0;
  int last_trig = -100;
  int log_cyc[64];
  int log_pos[64];
  int log_dist[64];
  int log_to[64];
  int log_up[64];

  int exp_seq[14] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 2};

  // Position after i completed samples: triangle wave of period 12 over 1..7
  function automatic logic [2:0] pos_of(input int i);
    int m;
    m = i % 12;
    return (m <= 6) ? 3'(1 + m) : 3'(13 - m);
  endfunction

  // Direction after i completed samples; reset starts going up at position 1
  function automatic logic up_of(input int i);
    int m;
    m = i % 12;
    return (i == 0) || (m >= 1 && m <= 6);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_samples(input int target, input int budget);
    int k;
    k = 0;
    while (n_samples < target && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("wait_samples", 32'(n_samples >= target), 32'd1);
  endtask

  task automatic wait_start(input int budget);
    int k;
    k = 0;
    while (meas_start !== 1'b1 && k < budget) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("wait_start", 32'(meas_start), 32'd1);
  endtask

  // Ranging block stand-in: answers rsp_delay cycles after meas_start
  always @(posedge clk) begin
    #2;
    meas_done = 1'b0;
    if (!rst_n) begin
      rsp_cnt = 0;
    end else begin
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          meas_done = 1'b1;
          meas_dist = rsp_dist;
        end
      end
      if (cyc == stray_cyc) begin
        meas_done = 1'b1;
        meas_dist = 16'hBEEF;
      end
      if (meas_start && rsp_delay > 0) rsp_cnt = rsp_delay;
    end
  end

  // Reference model: decides, from inputs seen at the end of cycle c, what cycle c+1 shows
  always @(posedge clk) begin
    int c;
    c = cyc;
    if (!rst_n) begin
      m_busy  = 1'b0;
      trig    = -100;
      rep     = -100;
      idx     = 0;
      e_spos  = 3'd0;
      e_sdist = '0;
      e_sto   = 1'b0;
    end else if (!m_busy) begin
      if (enable) begin
        m_busy = 1'b1;
        trig   = c + 1 + S;
        rep    = -1;
      end
    end else if (rep < 0) begin
      if (c > trig) begin
        if (meas_done) begin
          rep     = c + 1;
          e_spos  = pos_of(idx);
          e_sdist = meas_dist;
          e_sto   = 1'b0;
        end else if (c == trig + T) begin
          rep     = c + 1;
          e_spos  = pos_of(idx);
          e_sdist = '1;
          e_sto   = 1'b1;
        end
      end
    end else if (c == rep + 1) begin
      idx++;
      if (enable) begin
        trig = c + 1 + S;
        rep  = -1;
      end else begin
        m_busy = 1'b0;
      end
    end
    cyc     = c + 1;
    e_start = (cyc == trig);
    e_valid = (cyc == rep);
    e_busy  = m_busy;
  end

  // Per-cycle compare against the model, plus sample logging
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctr",   32'(ctr), 32'd1);
      chk("rst_up",    32'(sweep_up), 32'd1);
      chk("rst_busy",  32'(busy), 32'd0);
      chk("rst_start", 32'(meas_start), 32'd0);
      chk("rst_valid", 32'(sample_valid), 32'd0);
      chk("rst_spos",  32'(sample_pos), 32'd0);
      chk("rst_sdist", 32'(sample_dist), 32'd0);
      chk("rst_sto",   32'(sample_timeout), 32'd0);
    end else begin
      chk("ctr",        32'(ctr), 32'(pos_of(idx)));
      chk("sweep_up",   32'(sweep_up), 32'(up_of(idx)));
      chk("busy",       32'(busy), 32'(e_busy));
      chk("meas_start", 32'(meas_start), 32'(e_start));
      chk("valid",      32'(sample_valid), 32'(e_valid));
      chk("spos",       32'(sample_pos), 32'(e_spos));
      chk("sdist",      32'(sample_dist), 32'(e_sdist));
      chk("sto",        32'(sample_timeout), 32'(e_sto));
    end
    if (meas_start) last_trig = cyc;
    if (sample_valid && n_samples < 64) begin
      log_cyc[n_samples]  = cyc;
      log_pos[n_samples]  = int'(sample_pos);
      log_dist[n_samples] = int'(sample_dist);
      log_to[n_samples]   = int'(sample_timeout);
      log_up[n_samples]   = int'(sweep_up);
      n_samples++;
    end
  end

  initial begin
    int r;
    int base;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("init_ctr",  32'(ctr), 32'd1);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_up",   32'(sweep_up), 32'd1);

    // Scenario 1/2: normal sweep, reply 3 cycles after trigger
    rst_n  = 1'b1;
    enable = 1'b1;
    r      = cyc;
    wait_samples(14, 300);
    chk("first_cycle", 32'(log_cyc[0]), 32'(r + 9));
    chk("period",      32'(log_cyc[1] - log_cyc[0]), 32'd10);
    chk("first_dist",  32'(log_dist[0]), 32'h0123);
    chk("first_to",    32'(log_to[0]), 32'd0);
    for (int i = 0; i < 14; i++) chk("sequence", 32'(log_pos[i]), 32'(exp_seq[i]));
    chk("up_at_7",    32'(log_up[6]), 32'd1);
    chk("up_after_7", 32'(log_up[7]), 32'd0);
    chk("up_at_1",    32'(log_up[12]), 32'd0);
    chk("up_after_1", 32'(log_up[13]), 32'd1);

    // Scenario 3: no reply -> timeout sample at position 3
    rsp_delay = 0;
    wait_samples(15, 100);
    chk("to_pos",     32'(log_pos[14]), 32'd3);
    chk("to_dist",    32'(log_dist[14]), 32'hFFFF);
    chk("to_flag",    32'(log_to[14]), 32'd1);
    chk("to_latency", 32'(log_cyc[14] - last_trig), 32'd9);

    // Scenario 4: reply on the terminal cycle, stray done during settle
    rsp_delay = 8;
    rsp_dist  = 16'h0042;
    stray_cyc = cyc + 2;
    wait_samples(16, 100);
    chk("tc_pos",     32'(log_pos[15]), 32'd4);
    chk("tc_dist",    32'(log_dist[15]), 32'h0042);
    chk("tc_flag",    32'(log_to[15]), 32'd0);
    chk("tc_latency", 32'(log_cyc[15] - last_trig), 32'd9);

    // Scenario 6: reset during WAIT at position 5
    rsp_delay = 3;
    wait_start(60);
    chk("pre_rst_ctr", 32'(ctr), 32'd5);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst6_ctr",   32'(ctr), 32'd1);
    chk("rst6_busy",  32'(busy), 32'd0);
    chk("rst6_valid", 32'(sample_valid), 32'd0);
    chk("rst6_dist",  32'(sample_dist), 32'd0);
    chk("rst6_up",    32'(sweep_up), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    chk("rst6_nosample", 32'(n_samples), 32'd16);
    base  = n_samples;
    rst_n = 1'b1;

    // Scenario 5: drop enable during WAIT at position 3
    wait_samples(base + 2, 80);
    wait_start(40);
    chk("drop_ctr_before", 32'(ctr), 32'd3);
    @(posedge clk);
    #2;
    enable = 1'b0;
    wait_samples(base + 3, 40);
    chk("drop_pos", 32'(log_pos[base + 2]), 32'd3);
    repeat (2) @(posedge clk);
    #2;
    chk("drop_ctr",  32'(ctr), 32'd4);
    chk("drop_busy", 32'(busy), 32'd0);
    repeat (10) @(posedge clk);
    #2;
    chk("idle_quiet", 32'(n_samples), 32'(base + 3));
    enable = 1'b1;
    wait_samples(base + 4, 40);
    chk("resume_pos", 32'(log_pos[base + 3]), 32'd4);
    repeat (3) @(posedge clk);
    #2;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
